// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared widths, state encodings and bubble word for the fetch stage
package stage_if_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_PEND = 2'd2
    } if_state_e;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0;

    // Branch targets are always word aligned; the two low bits are dropped.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// rtl/stage_if_if.sv - word-fetch bus between the fetch stage and the memory controller
interface stage_if_if;
    import stage_if_pkg::*;

    logic                   mem_req_o;
    logic [InstAddrBus-1:0] mem_addr_o;
    logic                   mem_done_i;
    logic [InstBus-1:0]     mem_inst_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_done_i,
        input  mem_inst_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_done_i,
        output mem_inst_i
    );

endinterface

// File: rtl/stage_if_icache.sv
// rtl/stage_if_icache.sv - direct-mapped one-word-per-line instruction cache (if_icache)
module if_icache
    import stage_if_pkg::*;
#(
    parameter int LINES = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [29:0]        rd_word,
    output logic               hit,
    output logic [InstBus-1:0] rd_data,
    input  logic               wr_en,
    input  logic [29:0]        wr_word,
    input  logic [InstBus-1:0] wr_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [InstBus-1:0] data [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[29:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[29:IDX_W];

    // Only the valid bits need clearing; tag/data act as plain RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_data = data[rd_idx];

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - RV32I instruction-fetch stage; define ICACHE_EN to build the instruction cache
module stage_if
    import stage_if_pkg::*;
#(
    parameter int                     ICACHE_LINES = 128,
    parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   stall_i,
    input  logic                   branch_enable_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    stage_if_if.master             mem,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    if_state_e              state;
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     pend_inst;
    logic                   discard;
    logic                   mem_req;
    logic [InstAddrBus-1:0] mem_addr;
    logic [InstAddrBus-1:0] pc_q;
    logic [InstBus-1:0]     inst_q;

    logic                   branch_taken;
    logic [InstAddrBus-1:0] branch_target;
    logic                   cache_hit;
    logic [InstBus-1:0]     cache_data;
    logic                   unused_branch_lsbs;

    assign branch_taken       = branch_enable_i && !stall_i;
    assign branch_target      = word_align(branch_addr_i);
    assign unused_branch_lsbs = ^branch_addr_i[1:0];

`ifdef ICACHE_EN
    logic fill_en;

    // Fills happen on every completed fetch, including discarded ones.
    assign fill_en = rdy && (state == IF_WAIT) && mem.mem_done_i;

    if_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_word (pc[31:2]),
        .hit     (cache_hit),
        .rd_data (cache_data),
        .wr_en   (fill_en),
        .wr_word (mem_addr[31:2]),
        .wr_data (mem.mem_inst_i)
    );
`else
    localparam int unused_icache_lines = ICACHE_LINES;
    assign cache_hit  = 1'b0;
    assign cache_data = ZeroWord;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IF_IDLE;
            pc        <= RESET_PC;
            pend_inst <= ZeroWord;
            discard   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            pc_q      <= '0;
            inst_q    <= ZeroWord;
        end else if (rdy) begin
            unique case (state)
                IF_IDLE: begin
                    if (branch_taken) begin
                        pc     <= branch_target;
                        pc_q   <= '0;
                        inst_q <= ZeroWord;
                    end else if (cache_hit) begin
                        if (!stall_i) begin
                            pc_q   <= pc;
                            inst_q <= cache_data;
                            pc     <= pc + 32'd4;
                        end
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= IF_WAIT;
                        if (!stall_i) begin
                            pc_q   <= '0;
                            inst_q <= ZeroWord;
                        end
                    end
                end

                IF_WAIT: begin
                    if (mem.mem_done_i) begin
                        mem_req <= 1'b0;
                        state   <= IF_IDLE;
                        // A redirect landing on the completion edge squashes the word too.
                        if (discard || branch_taken) begin
                            discard <= 1'b0;
                            if (branch_taken) begin
                                pc <= branch_target;
                            end
                            if (!stall_i) begin
                                pc_q   <= '0;
                                inst_q <= ZeroWord;
                            end
                        end else if (!stall_i) begin
                            pc_q   <= mem_addr;
                            inst_q <= mem.mem_inst_i;
                            pc     <= mem_addr + 32'd4;
                        end else begin
                            pend_inst <= mem.mem_inst_i;
                            state     <= IF_PEND;
                        end
                    end else begin
                        if (branch_taken) begin
                            discard <= 1'b1;
                            pc      <= branch_target;
                        end
                        if (!stall_i) begin
                            pc_q   <= '0;
                            inst_q <= ZeroWord;
                        end
                    end
                end

                IF_PEND: begin
                    if (!stall_i) begin
                        state <= IF_IDLE;
                        if (branch_enable_i) begin
                            pc     <= branch_target;
                            pc_q   <= '0;
                            inst_q <= ZeroWord;
                        end else begin
                            pc_q   <= pc;
                            inst_q <= pend_inst;
                            pc     <= pc + 32'd4;
                        end
                    end
                end

                default: state <= IF_IDLE;
            endcase
        end
    end

    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = mem_addr;
    assign pc_o           = pc_q;
    assign inst_o         = inst_q;

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - directed table-driven bench for stage_if
module tb_stage_if;
    import stage_if_pkg::*;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        done;
        logic [31:0] minst;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        stall = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_addr = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];

    stage_if_if mem_bus();

    always #5 clk = ~clk;

    stage_if #(.ICACHE_LINES(128), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .stall_i         (stall),
        .branch_enable_i (br_en),
        .branch_addr_i   (br_addr),
        .mem             (mem_bus),
        .pc_o            (pc_o),
        .inst_o          (inst_o)
    );

    task automatic add(input logic s, input logic b, input logic [31:0] ba, input logic d,
                       input logic [31:0] mi, input logic er, input logic [31:0] ea,
                       input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.br = b; v.baddr = ba; v.done = d; v.minst = mi;
        v.ereq = er; v.eaddr = ea; v.epc = ep; v.einst = ei;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] ba,
                         input logic d, input logic [31:0] mi);
        stall              = s;
        br_en              = b;
        br_addr            = ba;
        mem_bus.mem_done_i = d;
        mem_bus.mem_inst_i = mi;
    endtask

    task automatic check(input string nm, input logic er, input logic [31:0] ea,
                         input logic [31:0] ep, input logic [31:0] ei);
        n_checks++;
        if ({mem_bus.mem_req_o, mem_bus.mem_addr_o, pc_o, inst_o} !== {er, ea, ep, ei}) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                     nm, mem_bus.mem_req_o, mem_bus.mem_addr_o, pc_o, inst_o, er, ea, ep, ei);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 32'h0, 0, 32'h0);

        //   stall br  baddr         done minst        req addr          pc            inst
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        32'h0);
        add(0, 0, 32'h0,        1, 32'h11,      0, 32'h0,        32'h0,        32'h11);
        add(1, 0, 32'h0,        0, 32'h0,       1, 32'h4,        32'h0,        32'h11);
        add(1, 0, 32'h0,        0, 32'h0,       1, 32'h4,        32'h0,        32'h11);
        add(1, 0, 32'h0,        1, 32'h22,      0, 32'h4,        32'h0,        32'h11);
        add(1, 0, 32'h0,        0, 32'h0,       0, 32'h4,        32'h0,        32'h11);
        add(1, 1, 32'h200,      0, 32'h0,       0, 32'h4,        32'h0,        32'h11);
        add(0, 0, 32'h0,        0, 32'h0,       0, 32'h4,        32'h4,        32'h22);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h8,        32'h0,        32'h0);
        add(0, 1, 32'h103,      0, 32'h0,       1, 32'h8,        32'h0,        32'h0);
        add(0, 0, 32'h0,        1, 32'h33,      0, 32'h8,        32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h100,      32'h0,        32'h0);
        add(0, 0, 32'h0,        1, 32'h44,      0, 32'h100,      32'h100,      32'h44);
        add(0, 1, 32'h40,       0, 32'h0,       0, 32'h100,      32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h40,       32'h0,        32'h0);
        add(1, 0, 32'h0,        1, 32'h55,      0, 32'h40,       32'h0,        32'h0);
        add(0, 1, 32'h80,       0, 32'h0,       0, 32'h40,       32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h80,       32'h0,        32'h0);
        add(0, 1, 32'h300,      1, 32'h66,      0, 32'h80,       32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h300,      32'h0,        32'h0);
        add(0, 0, 32'h0,        1, 32'h77,      0, 32'h300,      32'h300,      32'h77);
        add(0, 1, 32'hFFFFFFFC, 0, 32'h0,       0, 32'h300,      32'h0,        32'h0);
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'hFFFFFFFC, 32'h0,        32'h0);
        add(0, 0, 32'h0,        1, 32'h88,      0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h88);
`ifdef ICACHE_EN
        add(0, 0, 32'h0,        0, 32'h0,       0, 32'hFFFFFFFC, 32'h0,        32'h11);
`else
        add(0, 0, 32'h0,        0, 32'h0,       1, 32'h0,        32'h0,        32'h0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].baddr, tbl[i].done, tbl[i].minst);
            step();
            check($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].epc, tbl[i].einst);
        end

        // Get into WAIT, then pulse reset asynchronously mid-cycle.
        drive(0, 1, 32'h500, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 0, 32'h0);
        step();
        n_checks++;
        if (mem_bus.mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_req: got %b expected 1", mem_bus.mem_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 0, 32'h0, 32'h0, 32'h0);
        #1 rst_n = 1'b1;
        step();
        check("restart_req", 1, 32'h0, 32'h0, 32'h0);

        // rdy low freezes everything, including a pending completion.
        rdy = 1'b0;
        drive(0, 0, 32'h0, 1, 32'hAA);
        step();
        check("rdy_freeze", 1, 32'h0, 32'h0, 32'h0);
        rdy = 1'b1;
        drive(0, 0, 32'h0, 1, 32'h99);
        step();
        check("restart_deliver", 0, 32'h0, 32'h0, 32'h99);
        drive(0, 0, 32'h0, 0, 32'h0);

`ifdef ICACHE_EN
        for (int a = 1; a < 4; a++) begin
            step();
            check($sformatf("fill_req%0d", a), 1, 32'(a * 4), 32'h0, 32'h0);
            drive(0, 0, 32'h0, 1, 32'(a + 1));
            step();
            check($sformatf("fill_done%0d", a), 0, 32'(a * 4), 32'(a * 4), 32'(a + 1));
            drive(0, 0, 32'h0, 0, 32'h0);
        end
        drive(0, 1, 32'h0, 0, 32'h0);
        step();
        check("loop_branch", 0, 32'hC, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 0, 32'h0);
        for (int a = 0; a < 4; a++) begin
            step();
            check($sformatf("hit%0d", a), 0, 32'hC, 32'(a * 4), (a == 0) ? 32'h99 : 32'(a + 1));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
